// File: rtl/ibm_pkt_admit.sv
// Ingress packet admission: type filter, free-buffer check, one-cycle forward and TSN metadata FIFO.
// Define IBM_PKT_STATS_EN to build the saturating statistics counters (otherwise they read 0).
module ibm_pkt_admit #(
  parameter int DW            = 134,
  parameter int TYPE_LSB      = 80,
  parameter int TYPE_W        = 8,
  parameter int CPU_TYPE      = 1,
  parameter int MAX_RSVD_TYPE = 4,
  parameter int MD_W          = 24,
  parameter int ID_W          = 8,
  parameter int CNT_W         = 5,
  parameter int MIN_FREE      = 1,
  parameter int MD_DEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     in_data,
  input  logic              in_data_wr,
  input  logic              in_valid,
  input  logic [MD_W-1:0]   in_tsn_md,
  input  logic              in_tsn_md_wr,
  input  logic [CNT_W-1:0]  in_free_cnt,
  input  logic [ID_W-1:0]   in_buf_id,
  input  logic              in_buf_id_wr,
  output logic [CNT_W-1:0]  out_free_cnt,
  output logic [DW-1:0]     out_data,
  output logic              out_data_wr,
  output logic              out_valid,
  output logic              out_valid_wr,
  output logic [MD_W-1:0]   out_md,
  output logic              out_md_wr,
  output logic [1:0]        drop_pulse,
  output logic              err_pulse,
  output logic [31:0]       cnt_admit,
  output logic [31:0]       cnt_drop_type,
  output logic [31:0]       cnt_drop_nobuf
);

  localparam int         AW       = $clog2(MD_DEPTH);
  localparam int         HW       = MD_W - ID_W;
  localparam logic [1:0] FR_HEAD  = 2'b01;
  localparam logic [1:0] FR_TAIL  = 2'b10;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(MD_DEPTH);

  typedef enum logic [1:0] {IDLE, TRANS, DISC} state_t;

  state_t            state, state_nxt;
  logic [1:0]        frame;
  logic              is_head, is_tail;
  logic [TYPE_W-1:0] pkt_type;
  logic              type_rej, no_buf;

  logic [DW-1:0]     data_nxt;
  logic              data_wr_nxt, valid_nxt, valid_wr_nxt, err_nxt;
  logic [1:0]        drop_nxt;

  logic [HW-1:0]     md_reg;
  logic [HW-1:0]     fifo_mem [MD_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       fifo_cnt;
  logic              fifo_full, fifo_empty, push, pop;

  // Buffer IDs replace the low metadata bits, so those bits are never stored.
  logic              unused_md_lo;
  assign unused_md_lo = ^in_tsn_md[ID_W-1:0];

  assign frame      = in_data[DW-1:DW-2];
  assign is_head    = (frame == FR_HEAD);
  assign is_tail    = (frame == FR_TAIL);
  assign pkt_type   = in_data[TYPE_LSB +: TYPE_W];
  assign type_rej   = (pkt_type != TYPE_W'(CPU_TYPE)) && (pkt_type <= TYPE_W'(MAX_RSVD_TYPE));
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);
  assign no_buf     = (in_free_cnt < CNT_W'(MIN_FREE)) || fifo_full;
  assign pop        = in_buf_id_wr && !fifo_empty;

  assign out_free_cnt = in_free_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    data_nxt     = in_data;
    data_wr_nxt  = 1'b0;
    valid_nxt    = 1'b0;
    valid_wr_nxt = 1'b0;
    err_nxt      = 1'b0;
    drop_nxt     = 2'b00;
    push         = 1'b0;
    if (in_data_wr) begin
      case (state)
        IDLE: begin
          if (is_head) begin
            if (type_rej) begin
              drop_nxt  = 2'b01;
              state_nxt = DISC;
            end else if (no_buf) begin
              drop_nxt  = 2'b10;
              state_nxt = DISC;
            end else begin
              data_wr_nxt = 1'b1;
              state_nxt   = TRANS;
            end
          end
        end
        TRANS: begin
          data_wr_nxt = 1'b1;
          // A head inside an open packet closes the old one as a bad tail.
          if (is_head) begin
            data_nxt[DW-1:DW-2] = FR_TAIL;
            valid_wr_nxt        = 1'b1;
            err_nxt             = 1'b1;
            state_nxt           = DISC;
          end else if (is_tail) begin
            valid_nxt    = in_valid;
            valid_wr_nxt = 1'b1;
            push         = in_valid;
            state_nxt    = IDLE;
          end
        end
        DISC: begin
          if (is_tail) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data     <= '0;
      out_data_wr  <= 1'b0;
      out_valid    <= 1'b0;
      out_valid_wr <= 1'b0;
      drop_pulse   <= 2'b00;
      err_pulse    <= 1'b0;
    end else begin
      if (data_wr_nxt) out_data <= data_nxt;
      out_data_wr  <= data_wr_nxt;
      out_valid    <= valid_nxt;
      out_valid_wr <= valid_wr_nxt;
      drop_pulse   <= drop_nxt;
      err_pulse    <= err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            md_reg <= '0;
    else if (in_tsn_md_wr) md_reg <= in_tsn_md[MD_W-1:ID_W];
  end

  // Admission refuses heads while full and only one packet is open, so push cannot overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + (AW+1)'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= md_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_md    <= '0;
      out_md_wr <= 1'b0;
    end else begin
      if (pop) out_md <= {fifo_mem[rd_ptr], in_buf_id};
      out_md_wr <= pop;
    end
  end

`ifdef IBM_PKT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_admit      <= '0;
      cnt_drop_type  <= '0;
      cnt_drop_nobuf <= '0;
    end else begin
      if (push && (cnt_admit != '1))            cnt_admit      <= cnt_admit + 32'd1;
      if (drop_nxt[0] && (cnt_drop_type != '1))  cnt_drop_type  <= cnt_drop_type + 32'd1;
      if (drop_nxt[1] && (cnt_drop_nobuf != '1)) cnt_drop_nobuf <= cnt_drop_nobuf + 32'd1;
    end
  end
`else
  assign cnt_admit      = '0;
  assign cnt_drop_type  = '0;
  assign cnt_drop_nobuf = '0;
`endif

endmodule

// File: tb/tb_ibm_pkt_admit.sv
// Directed self-checking bench for ibm_pkt_admit with hand-computed expectations.
module tb_ibm_pkt_admit;

  localparam int DW = 134;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   in_data;
  logic            in_data_wr, in_valid, in_tsn_md_wr, in_buf_id_wr;
  logic [23:0]     in_tsn_md;
  logic [4:0]      in_free_cnt, out_free_cnt;
  logic [7:0]      in_buf_id;
  logic [DW-1:0]   out_data;
  logic            out_data_wr, out_valid, out_valid_wr, out_md_wr, err_pulse;
  logic [23:0]     out_md;
  logic [1:0]      drop_pulse;
  logic [31:0]     cnt_admit, cnt_drop_type, cnt_drop_nobuf;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_admit = 0, exp_type = 0, exp_nobuf = 0;

  ibm_pkt_admit dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_data_wr(in_data_wr), .in_valid(in_valid),
    .in_tsn_md(in_tsn_md), .in_tsn_md_wr(in_tsn_md_wr),
    .in_free_cnt(in_free_cnt), .in_buf_id(in_buf_id), .in_buf_id_wr(in_buf_id_wr),
    .out_free_cnt(out_free_cnt),
    .out_data(out_data), .out_data_wr(out_data_wr),
    .out_valid(out_valid), .out_valid_wr(out_valid_wr),
    .out_md(out_md), .out_md_wr(out_md_wr),
    .drop_pulse(drop_pulse), .err_pulse(err_pulse),
    .cnt_admit(cnt_admit), .cnt_drop_type(cnt_drop_type), .cnt_drop_nobuf(cnt_drop_nobuf)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk_beat(input logic [1:0] fr, input logic [7:0] ty,
                                            input logic [31:0] tag);
    logic [DW-1:0] b;
    b = '0;
    b[DW-1:DW-2] = fr;
    b[87:80]     = ty;
    b[31:0]      = tag;
    return b;
  endfunction

  function automatic logic [31:0] cnt_exp(input int v);
`ifdef IBM_PKT_STATS_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v & 0);
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    in_data_wr   = 1'b0;
    in_valid     = 1'b0;
    in_tsn_md_wr = 1'b0;
    in_buf_id_wr = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] fr, input logic [7:0] ty,
                               input logic [31:0] tag, input logic vld);
    in_data    = mk_beat(fr, ty, tag);
    in_data_wr = 1'b1;
    in_valid   = vld;
    tick();
  endtask

  task automatic load_md(input logic [23:0] md);
    in_tsn_md    = md;
    in_tsn_md_wr = 1'b1;
    tick();
  endtask

  task automatic pop_md(input logic [7:0] id, input logic [23:0] exp, input string tag);
    in_buf_id    = id;
    in_buf_id_wr = 1'b1;
    tick();
    checkOutput({tag, "_wr"}, DW'(out_md_wr), DW'(1'b1));
    checkOutput(tag, DW'(out_md), DW'(exp));
  endtask

  // Two-beat packet that must be admitted and pushed into the metadata FIFO.
  task automatic admit_pkt(input logic [23:0] md, input logic [31:0] tag);
    load_md(md);
    applyStimulus(2'b01, 8'd8, tag, 1'b0);
    checkOutput("adm_head_wr", DW'(out_data_wr), DW'(1'b1));
    applyStimulus(2'b10, 8'd8, tag + 1, 1'b1);
    exp_admit++;
    checkOutput("adm_tail_vld", DW'({out_valid_wr, out_valid}), DW'(2'b11));
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = '0; in_data_wr = 0; in_valid = 0; in_tsn_md = '0; in_tsn_md_wr = 0;
    in_free_cnt = 5'd3; in_buf_id = '0; in_buf_id_wr = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_data_wr", DW'(out_data_wr), '0);
    checkOutput("rst_data", out_data, '0);
    checkOutput("rst_flags", DW'({out_valid, out_valid_wr, out_md_wr, drop_pulse, err_pulse}), '0);
    checkOutput("rst_md", DW'(out_md), '0);
    checkOutput("free_copy", DW'(out_free_cnt), DW'(5'd3));
    rst_n = 1'b1;

    // Type 1 packet, four beats, then its buffer ID.
    load_md(24'h123456);
    applyStimulus(2'b01, 8'd1, 32'h100, 1'b0);
    checkOutput("t1_head", out_data, mk_beat(2'b01, 8'd1, 32'h100));
    checkOutput("t1_head_wr", DW'({out_data_wr, out_valid_wr}), DW'(2'b10));
    applyStimulus(2'b11, 8'd1, 32'h101, 1'b0);
    checkOutput("t1_body1", out_data, mk_beat(2'b11, 8'd1, 32'h101));
    applyStimulus(2'b11, 8'd1, 32'h102, 1'b0);
    checkOutput("t1_body2", out_data, mk_beat(2'b11, 8'd1, 32'h102));
    applyStimulus(2'b10, 8'd1, 32'h103, 1'b1);
    exp_admit++;
    checkOutput("t1_tail", out_data, mk_beat(2'b10, 8'd1, 32'h103));
    checkOutput("t1_tail_vld", DW'({out_data_wr, out_valid_wr, out_valid}), DW'(3'b111));
    pop_md(8'h2A, 24'h12342A, "t1_md");
    checkOutput("cnt_admit1", DW'(cnt_admit), DW'(cnt_exp(exp_admit)));
    tick();
    checkOutput("md_wr_idle", DW'(out_md_wr), '0);

    // Reserved type 3 dropped, type 5 admitted.
    applyStimulus(2'b01, 8'd3, 32'h200, 1'b0);
    exp_type++;
    checkOutput("t3_drop", DW'({out_data_wr, drop_pulse}), DW'(3'b001));
    checkOutput("cnt_drop_type", DW'(cnt_drop_type), DW'(cnt_exp(exp_type)));
    applyStimulus(2'b11, 8'd3, 32'h201, 1'b0);
    checkOutput("t3_body", DW'({out_data_wr, drop_pulse}), '0);
    applyStimulus(2'b10, 8'd3, 32'h202, 1'b1);
    checkOutput("t3_tail", DW'({out_data_wr, out_valid_wr}), '0);
    applyStimulus(2'b01, 8'd5, 32'h210, 1'b0);
    checkOutput("t5_head", out_data, mk_beat(2'b01, 8'd5, 32'h210));
    checkOutput("t5_head_wr", DW'({out_data_wr, drop_pulse}), DW'(3'b100));
    applyStimulus(2'b10, 8'd5, 32'h211, 1'b1);
    exp_admit++;
    checkOutput("t5_tail", DW'({out_valid_wr, out_valid}), DW'(2'b11));
    pop_md(8'h01, 24'h123401, "t5_md");

    // No free buffer, then exactly MIN_FREE.
    in_free_cnt = 5'd0;
    applyStimulus(2'b01, 8'd6, 32'h300, 1'b0);
    exp_nobuf++;
    checkOutput("t6_nobuf", DW'({out_data_wr, drop_pulse}), DW'(3'b010));
    checkOutput("cnt_drop_nobuf", DW'(cnt_drop_nobuf), DW'(cnt_exp(exp_nobuf)));
    applyStimulus(2'b10, 8'd6, 32'h301, 1'b1);
    checkOutput("t6_tail_drop", DW'({out_data_wr, out_valid_wr}), '0);
    in_free_cnt = 5'd1;
    applyStimulus(2'b01, 8'd6, 32'h310, 1'b0);
    checkOutput("t6_adm", DW'({out_data_wr, drop_pulse}), DW'(3'b100));
    applyStimulus(2'b10, 8'd6, 32'h311, 1'b1);
    exp_admit++;
    pop_md(8'h02, 24'h123402, "t6_md");

    // Fill the FIFO; the fifth head sees it full.
    in_free_cnt = 5'd3;
    for (int i = 0; i < 4; i++) admit_pkt({16'hC000 + 16'(i), 8'hFF}, 32'h400 + 32'(i * 2));
    applyStimulus(2'b01, 8'd8, 32'h480, 1'b0);
    exp_nobuf++;
    checkOutput("full_drop", DW'({out_data_wr, drop_pulse}), DW'(3'b010));
    applyStimulus(2'b10, 8'd8, 32'h481, 1'b1);
    for (int i = 0; i < 4; i++)
      pop_md(8'h10 + 8'(i), {16'hC000 + 16'(i), 8'h10 + 8'(i)}, "fifo_order");
    in_buf_id    = 8'h77;
    in_buf_id_wr = 1'b1;
    tick();
    checkOutput("pop_empty", DW'(out_md_wr), '0);
    checkOutput("cnt_admit2", DW'(cnt_admit), DW'(cnt_exp(exp_admit)));
    checkOutput("cnt_nobuf2", DW'(cnt_drop_nobuf), DW'(cnt_exp(exp_nobuf)));

    // Missing tail: second head closes the first packet and is discarded.
    applyStimulus(2'b01, 8'd7, 32'h500, 1'b0);
    applyStimulus(2'b11, 8'd7, 32'h501, 1'b0);
    checkOutput("fe_body", out_data, mk_beat(2'b11, 8'd7, 32'h501));
    applyStimulus(2'b01, 8'd7, 32'h600, 1'b0);
    checkOutput("fe_beat", out_data, mk_beat(2'b10, 8'd7, 32'h600));
    checkOutput("fe_flags", DW'({out_data_wr, out_valid_wr, out_valid, err_pulse, drop_pulse}),
                DW'(6'b110100));
    applyStimulus(2'b11, 8'd7, 32'h601, 1'b0);
    checkOutput("fe_disc_body", DW'({out_data_wr, err_pulse}), '0);
    applyStimulus(2'b10, 8'd7, 32'h602, 1'b1);
    checkOutput("fe_disc_tail", DW'({out_data_wr, out_valid_wr}), '0);
    in_buf_id    = 8'h55;
    in_buf_id_wr = 1'b1;
    tick();
    checkOutput("fe_no_push", DW'(out_md_wr), '0);

    // Simultaneous push and pop at occupancy 3.
    for (int i = 0; i < 3; i++) admit_pkt({16'hD000 + 16'(i), 8'h00}, 32'h700 + 32'(i * 2));
    load_md(24'hD00300);
    applyStimulus(2'b01, 8'd9, 32'h710, 1'b0);
    in_buf_id    = 8'h20;
    in_buf_id_wr = 1'b1;
    applyStimulus(2'b10, 8'd9, 32'h711, 1'b1);
    exp_admit++;
    checkOutput("pp_md", DW'({out_md_wr, out_md}), DW'({1'b1, 24'hD00020}));
    admit_pkt(24'hDA0000, 32'h720);
    applyStimulus(2'b01, 8'd9, 32'h730, 1'b0);
    exp_nobuf++;
    checkOutput("pp_full", DW'({out_data_wr, drop_pulse}), DW'(3'b010));
    applyStimulus(2'b10, 8'd9, 32'h731, 1'b1);
    pop_md(8'h21, 24'hD00121, "pp_d1");
    pop_md(8'h22, 24'hD00222, "pp_d2");
    pop_md(8'h23, 24'hD00323, "pp_d3");
    pop_md(8'h24, 24'hDA0024, "pp_da");
    checkOutput("cnt_admit3", DW'(cnt_admit), DW'(cnt_exp(exp_admit)));

    // Reset in the middle of an admitted packet; also leaves an entry to be discarded.
    admit_pkt(24'hEE0000, 32'h800);
    applyStimulus(2'b01, 8'd9, 32'h810, 1'b0);
    applyStimulus(2'b11, 8'd9, 32'h811, 1'b0);
    rst_n = 1'b0;
    #2;
    checkOutput("mid_rst_out", out_data, '0);
    checkOutput("mid_rst_flags", DW'({out_data_wr, out_valid_wr, out_md_wr, drop_pulse, err_pulse}), '0);
    checkOutput("mid_rst_cnt", DW'({cnt_admit, cnt_drop_type, cnt_drop_nobuf}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(2'b11, 8'd9, 32'h812, 1'b0);
    checkOutput("resid_body", DW'(out_data_wr), '0);
    applyStimulus(2'b10, 8'd9, 32'h813, 1'b1);
    checkOutput("resid_tail", DW'({out_data_wr, out_valid_wr}), '0);
    in_buf_id    = 8'h33;
    in_buf_id_wr = 1'b1;
    tick();
    checkOutput("rst_fifo_empty", DW'(out_md_wr), '0);
    applyStimulus(2'b01, 8'd1, 32'h900, 1'b0);
    checkOutput("post_rst_adm", out_data, mk_beat(2'b01, 8'd1, 32'h900));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
